mips_mc_ctrl: RTL
=================

# mips_mc_ctrl

Multicycle control unit for the MIPS core: a Moore/Mealy FSM that sequences a shared-memory multicycle datapath (single unified instruction/data memory, IR, A/B, ALUOut, MDR registers) through fetch, decode, execute, memory and write-back steps. It drives every datapath mux/enable from the IR opcode and ALU zero flag, stalls on a memory ready handshake, halts on illegal opcodes and counts retired instructions.

## Interface

- CNT_W, default 32: width of retired-instruction counter.

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current read/write this cycle
- pc_en  out  1  PC load enable
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load enable
- reg_dst  out  1  write register: 0=rt, 1=rd
- mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  00=add, 01=sub, 10=funct-decoded
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
- state  out  4  current FSM state encoding
- halted  out  1  FSM in HALT
- instr_count  out  CNT_W  retired instructions, saturating

## Operation

- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, ADDI_EXEC 9, ADDI_WB 10, JUMP 11, HALT 12. Unused encodings -> HALT.
- Every output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_en = mem_ready (Mealy). Stay until mem_ready=1, then DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next: 000000->R_EXEC, 100011/101011->MEM_ADDR, 000100->BRANCH, 001000->ADDI_EXEC, 000010->JUMP (see Configuration), other->HALT.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; lw->MEM_RD, sw->MEM_WR.
- MEM_RD: mem_read=1, iord=1; hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WR: mem_write=1, iord=1; hold until mem_ready -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB: reg_write=1, reg_dst=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero -> FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB: reg_write=1, reg_dst=0 -> FETCH.
- JUMP: pc_src=10, pc_en=1 -> FETCH.
- HALT: halted=1, all controls 0, stays until rst_n low.
- instr_count: +1 on each transition into FETCH from a final state; saturates at all-ones; HALT entry does not count.
- mem_ready ignored outside FETCH/MEM_RD/MEM_WR.

## Timing

- Reset (rst_n=0, async): state=FETCH, instr_count=0, halted=0; all control outputs forced 0 combinationally while rst_n=0 (mem_read not asserted in reset).
- First fetch request on cycle after rst_n release; reset mid-instruction aborts immediately, no partial write asserted after reset edge.
- Latency with mem_ready tied 1: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3 cycles; each low cycle of mem_ready in a memory state adds one.
- mem_read/mem_write/iord held stable for the whole wait.

## Configuration

- MC_JUMP_EN defined: opcode 000010 -> JUMP as above.
- Undefined: opcode 000010 treated as illegal -> HALT; JUMP state encoding unused (-> HALT if ever reached).

## Test plan

- Reset: rst_n=0 -> all controls 0, state=0, instr_count=0, halted=0; release -> mem_read=1, iord=0 next cycle.
- R-type, mem_ready=1: state 0,1,6,7,0; reg_write=1 & reg_dst=1 in state 7 only; instr_count=1 after 4 cycles.
- lw with mem_ready low 3 cycles in MEM_RD: mem_read=1, iord=1 held 4 cycles; total 8 cycles; reg_write & mem_to_reg in state 4.
- beq zero=0 -> pc_en=0 in BRANCH; zero=1 -> pc_en=1, pc_src=01; both 3 cycles, count +1 each.
- Opcode 111111 -> HALT, halted=1, count unchanged, no further mem_read until reset; opcode 000010 -> JUMP (pc_en=1, pc_src=10) with MC_JUMP_EN, HALT without.
- CNT_W=4, 20 addi instructions -> instr_count saturates at 15; rst_n pulse during MEM_WR -> mem_write drops same cycle, count=0.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
// ---------------------------------------------------------------------------
// mips_mc_ctrl
//
// Multicycle MIPS control unit. Sequences a shared-memory multicycle datapath
// (unified instruction/data memory, IR, A/B, ALUOut, MDR) through fetch,
// decode, execute, memory and write-back steps. Stalls on a memory ready
// handshake, halts on illegal opcodes and counts retired instructions.
//
// Optional feature macro: MC_JUMP_EN
//   defined   : opcode 000010 (j) executes through the JUMP state
//   undefined : opcode 000010 is illegal and halts; JUMP encoding unused
//
// Memory handshake: in FETCH, MEM_RD and MEM_WR the request (o_mem_read or
// o_mem_write, with o_iord) is raised and held unchanged every cycle until
// i_mem_ready is sampled high on a rising edge; that edge completes the
// transfer and the FSM moves on. i_mem_ready is ignored in all other states.
//
// Parameters
//   CNT_W          width of the retired-instruction counter
//
// Ports
//   i_clk          clock, all state on rising edge
//   i_rst_n        asynchronous active-low reset
//   i_opcode[5:0]  IR[31:26], valid from DECODE onward
//   i_zero         ALU zero flag
//   i_mem_ready    memory completes current read/write this cycle
//   o_pc_en        PC load enable
//   o_iord         memory address select: 0=PC, 1=ALUOut
//   o_mem_read     memory read request
//   o_mem_write    memory write request
//   o_ir_write     IR load enable
//   o_reg_dst      write register: 0=rt, 1=rd
//   o_mem_to_reg   write data: 0=ALUOut, 1=MDR
//   o_reg_write    register file write enable
//   o_alu_src_a    0=PC, 1=A
//   o_alu_src_b    00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
//   o_alu_op       00=add, 01=sub, 10=funct-decoded
//   o_pc_src       00=ALU result, 01=ALUOut, 10=jump target
//   o_state        current FSM state encoding
//   o_halted       FSM is in HALT
//   o_instr_count  retired instructions, saturating
// ---------------------------------------------------------------------------
module mips_mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [5:0]       i_opcode,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    output logic             o_pc_en,
    output logic             o_iord,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_ir_write,
    output logic             o_reg_dst,
    output logic             o_mem_to_reg,
    output logic             o_reg_write,
    output logic             o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output logic [1:0]       o_alu_op,
    output logic [1:0]       o_pc_src,
    output logic [3:0]       o_state,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_ADDI_EXEC = 4'd9,
        S_ADDI_WB   = 4'd10,
        S_JUMP      = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;

    logic       w_pc_en;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_src;
    logic       w_retire;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and control outputs
    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        w_pc_en      = 1'b0;
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_pc_src     = 2'b00;

        case (r_state)
            S_FETCH: begin
                // PC+4 computed while the instruction is read; IR and PC
                // load only on the cycle the memory completes.
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = i_mem_ready;
                w_pc_en     = i_mem_ready;
                if (i_mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative branch target lands in ALUOut.
                w_alu_src_b = 2'b11;
                case (i_opcode)
                    OP_RTYPE:      w_next = S_R_EXEC;
                    OP_LW, OP_SW:  w_next = S_MEM_ADDR;
                    OP_BEQ:        w_next = S_BRANCH;
                    OP_ADDI:       w_next = S_ADDI_EXEC;
`ifdef MC_JUMP_EN
                    OP_J:          w_next = S_JUMP;
`endif
                    default:       w_next = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                if (i_opcode == OP_LW) begin
                    w_next = S_MEM_RD;
                end else if (i_opcode == OP_SW) begin
                    w_next = S_MEM_WR;
                end else begin
                    w_next = S_HALT;
                end
            end
            S_MEM_RD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                if (i_mem_ready) begin
                    w_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_next       = S_FETCH;
                w_retire     = 1'b1;
            end
            S_MEM_WR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                if (i_mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_R_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                w_next      = S_R_WB;
            end
            S_R_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_next      = S_FETCH;
                w_retire    = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b01;
                w_pc_src    = 2'b01;
                w_pc_en     = i_zero;
                w_next      = S_FETCH;
                w_retire    = 1'b1;
            end
            S_ADDI_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
                w_retire    = 1'b1;
            end
            S_JUMP: begin
`ifdef MC_JUMP_EN
                w_pc_src = 2'b10;
                w_pc_en  = 1'b1;
                w_next   = S_FETCH;
                w_retire = 1'b1;
`else
                w_next = S_HALT;
`endif
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_HALT;
            end
        endcase
    end

    // Retired-instruction counter, sticks at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (w_retire && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Controls are gated by reset so that nothing (in particular the FETCH
    // read request) is asserted while rst_n is low.
    assign o_pc_en       = i_rst_n & w_pc_en;
    assign o_iord        = i_rst_n & w_iord;
    assign o_mem_read    = i_rst_n & w_mem_read;
    assign o_mem_write   = i_rst_n & w_mem_write;
    assign o_ir_write    = i_rst_n & w_ir_write;
    assign o_reg_dst     = i_rst_n & w_reg_dst;
    assign o_mem_to_reg  = i_rst_n & w_mem_to_reg;
    assign o_reg_write   = i_rst_n & w_reg_write;
    assign o_alu_src_a   = i_rst_n & w_alu_src_a;
    assign o_alu_src_b   = {2{i_rst_n}} & w_alu_src_b;
    assign o_alu_op      = {2{i_rst_n}} & w_alu_op;
    assign o_pc_src      = {2{i_rst_n}} & w_pc_src;
    assign o_state       = r_state;
    assign o_halted      = (r_state == S_HALT);
    assign o_instr_count = r_count;

endmodule
